// File: rtl/axis_crop_pkg.sv
// ============================================================================
// Module   : axis_crop_pkg
// Brief    : Shared state encoding and constants for the axis_crop block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_crop_pkg;

    localparam logic [0:0] ST_WAIT_SOF = 1'b0;
    localparam logic [0:0] ST_ACTIVE   = 1'b1;

    typedef enum logic [0:0] {
        S_WAIT_SOF = ST_WAIT_SOF,
        S_ACTIVE   = ST_ACTIVE
    } crop_state_t;

    localparam int ERRCNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/axis_crop_oreg.sv
// ============================================================================
// Module   : axis_crop_oreg
// Brief    : Single-entry registered AXI-Stream output stage with pass-through
//            ready (upstream ready when empty or draining this cycle).
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_crop_oreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_user,
    input  logic              i_last,
    output logic              o_s_tready,
    output logic              o_m_tvalid,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic              o_m_tuser,
    output logic              o_m_tlast,
    input  logic              i_m_tready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_user;
    logic              r_last;

    assign o_s_tready = ~r_valid | i_m_tready;

    // i_load is only asserted by the parent when o_s_tready is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_user  <= i_user;
            r_last  <= i_last;
        end else if (i_m_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_tvalid = r_valid;
    assign o_m_tdata  = r_data;
    assign o_m_tuser  = r_user;
    assign o_m_tlast  = r_last;

endmodule

`default_nettype wire

// File: rtl/axis_crop.sv
// ============================================================================
// Module   : axis_crop
// Brief    : AXI-Stream raster window extractor; regenerates tuser/tlast for
//            the cropped image. Define AXIS_CROP_ERRCNT_EN to count short lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_crop
    import axis_crop_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C_IMG_WBITS-1:0]   win_left,
    input  logic [C_IMG_HBITS-1:0]   win_top,
    input  logic [C_IMG_WBITS-1:0]   win_width,
    input  logic [C_IMG_HBITS-1:0]   win_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [ERRCNT_W-1:0]      err_short_lines
);

    localparam logic [C_IMG_WBITS-1:0] c_x_inc  = {{(C_IMG_WBITS-1){1'b0}}, 1'b1};
    localparam logic [C_IMG_HBITS-1:0] c_y_inc  = {{(C_IMG_HBITS-1){1'b0}}, 1'b1};
    localparam logic [C_IMG_WBITS:0]   c_xw_inc = {{C_IMG_WBITS{1'b0}}, 1'b1};

    crop_state_t              r_state;
    logic [C_IMG_WBITS-1:0]   r_x;
    logic [C_IMG_HBITS-1:0]   r_y;
    logic [C_IMG_WBITS-1:0]   r_left;
    logic [C_IMG_WBITS-1:0]   r_width;
    logic [C_IMG_HBITS-1:0]   r_top;
    logic [C_IMG_HBITS-1:0]   r_height;
    logic                     r_sent_sof;

    logic                     w_accept;
    logic                     w_sof;
    logic                     w_active;
    logic [C_IMG_WBITS-1:0]   w_x;
    logic [C_IMG_HBITS-1:0]   w_y;
    logic [C_IMG_WBITS-1:0]   w_left;
    logic [C_IMG_WBITS-1:0]   w_width;
    logic [C_IMG_HBITS-1:0]   w_top;
    logic [C_IMG_HBITS-1:0]   w_height;
    logic                     w_sent;
    logic [C_IMG_WBITS:0]     w_xend;
    logic [C_IMG_HBITS:0]     w_yend;
    logic                     w_inwin;
    logic                     w_keep;
    logic                     w_last_col;

    assign w_accept = s_axis_tvalid & s_axis_tready;
    assign w_sof    = w_accept & s_axis_tuser;
    assign w_active = w_sof | (r_state == S_ACTIVE);

    // A tuser beat is processed as pixel (0,0) against the freshly sampled window.
    assign w_x      = w_sof ? '0           : r_x;
    assign w_y      = w_sof ? '0           : r_y;
    assign w_left   = w_sof ? win_left     : r_left;
    assign w_width  = w_sof ? win_width    : r_width;
    assign w_top    = w_sof ? win_top      : r_top;
    assign w_height = w_sof ? win_height   : r_height;
    assign w_sent   = w_sof ? 1'b0         : r_sent_sof;

    assign w_xend = {1'b0, w_left} + {1'b0, w_width};
    assign w_yend = {1'b0, w_top}  + {1'b0, w_height};

    assign w_inwin = ({1'b0, w_x} >= {1'b0, w_left}) && ({1'b0, w_x} < w_xend) &&
                     ({1'b0, w_y} >= {1'b0, w_top})  && ({1'b0, w_y} < w_yend);

    assign w_keep     = w_accept & w_active & w_inwin;
    assign w_last_col = (({1'b0, w_x} + c_xw_inc) == w_xend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_WAIT_SOF;
            r_x        <= '0;
            r_y        <= '0;
            r_left     <= '0;
            r_width    <= '0;
            r_top      <= '0;
            r_height   <= '0;
            r_sent_sof <= 1'b0;
        end else begin
            if (w_sof) begin
                r_state  <= S_ACTIVE;
                r_left   <= win_left;
                r_width  <= win_width;
                r_top    <= win_top;
                r_height <= win_height;
            end
            if (w_accept && w_active) begin
                r_sent_sof <= w_sent | w_keep;
                if (s_axis_tlast) begin
                    r_x <= '0;
                    r_y <= (&w_y) ? w_y : w_y + c_y_inc;
                end else begin
                    r_x <= (&w_x) ? w_x : w_x + c_x_inc;
                    r_y <= w_y;
                end
            end
        end
    end

`ifdef AXIS_CROP_ERRCNT_EN
    logic                w_short;
    logic [ERRCNT_W-1:0] r_err;

    // Kept beat closing its row before the window's right edge.
    assign w_short = w_keep & s_axis_tlast & ~w_last_col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_short && !(&r_err)) begin
            r_err <= r_err + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_short_lines = r_err;
`else
    assign err_short_lines = '0;
`endif

    axis_crop_oreg #(
        .DATA_W (C_PIXEL_WIDTH)
    ) u_oreg (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_keep),
        .i_data     (s_axis_tdata),
        .i_user     (~w_sent),
        .i_last     (w_last_col | s_axis_tlast),
        .o_s_tready (s_axis_tready),
        .o_m_tvalid (m_axis_tvalid),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tuser  (m_axis_tuser),
        .o_m_tlast  (m_axis_tlast),
        .i_m_tready (m_axis_tready)
    );

endmodule

`default_nettype wire

// File: tb/tb_axis_crop.sv
// ============================================================================
// Module   : tb_axis_crop
// Brief    : Directed self-checking bench for axis_crop (8x4 test frames).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_crop;

    import axis_crop_pkg::*;

`ifdef AXIS_CROP_ERRCNT_EN
    localparam logic [31:0] EXP_ERR1 = 32'd1;
`else
    localparam logic [31:0] EXP_ERR1 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] win_left, win_top, win_width, win_height;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tuser, s_axis_tlast;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast;
    logic        m_axis_tready;
    logic [ERRCNT_W-1:0] err_short_lines;

    logic        tog = 1'b0;
    logic        phase = 1'b0;
    logic        rdy = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [9:0]  q[$];
    logic [9:0]  exp_q[$];

    assign m_axis_tready = tog ? phase : rdy;

    always #5 clk = ~clk;

    axis_crop dut (
        .clk             (clk),
        .reset           (reset),
        .win_left        (win_left),
        .win_top         (win_top),
        .win_width       (win_width),
        .win_height      (win_height),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .err_short_lines (err_short_lines)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            chk(tag, {22'd0, q[i]}, {22'd0, exp_q[i]});
    endtask

    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        logic done;
        done          = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = s_axis_tready;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_row(input int y, input int len, input logic sof, input logic eol);
        logic [3:0] yy, xx;
        yy = y[3:0];
        for (int x = 0; x < len; x++) begin
            xx = x[3:0];
            send_beat({yy, xx}, sof && (x == 0), eol && (x == len - 1));
        end
    endtask

    task automatic send_frame();
        for (int y = 0; y < 4; y++) send_row(y, 8, y == 0, 1'b1);
    endtask

    task automatic set_win(input int l, input int t, input int w, input int h);
        win_left   = l[11:0];
        win_top    = t[11:0];
        win_width  = w[11:0];
        win_height = h[11:0];
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic exp_std();
        exp_q = '{10'h212, 10'h013, 10'h014, 10'h115, 10'h022, 10'h023, 10'h024, 10'h125};
    endtask

    // Ready pattern generator for the stall test
    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase = ~phase;
        end
    end

    // Output monitor: records handshakes and checks hold-while-stalled
    initial begin
        logic [9:0] prev;
        logic       stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (stall && m_axis_tvalid)
                chk("stall_hold", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, prev});
            if (!reset && m_axis_tvalid && m_axis_tready)
                q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            stall = m_axis_tvalid && !m_axis_tready;
            prev  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        set_win(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tdata",  {24'd0, m_axis_tdata}, 32'd0);
        chk("rst_tuser",  {31'd0, m_axis_tuser}, 32'd0);
        chk("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_err",    {16'd0, err_short_lines}, 32'd0);
        chk("rst_sready", {31'd0, s_axis_tready}, 32'd1);
        reset = 1'b0;

        // One-pixel window: single beat appears one cycle after acceptance
        set_win(0, 0, 1, 1);
        send_beat(8'hA5, 1'b1, 1'b1);
        chk("lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("lat_data",  {24'd0, m_axis_tdata}, 32'hA5);
        chk("lat_user",  {31'd0, m_axis_tuser}, 32'd1);
        chk("lat_last",  {31'd0, m_axis_tlast}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_drop", {31'd0, m_axis_tvalid}, 32'd0);

        // Basic crop at full throughput
        set_win(2, 1, 4, 2);
        q.delete();
        send_frame();
        drain();
        exp_std();
        check_q("t1");

        // Same crop with alternating downstream ready
        q.delete();
        tog = 1'b1;
        send_frame();
        drain();
        drain();
        tog = 1'b0;
        check_q("t2");

        // Short row 1 (ends x=3) and empty row 2 (ends x=1)
        q.delete();
        send_row(0, 8, 1'b1, 1'b1);
        send_row(1, 4, 1'b0, 1'b1);
        send_row(2, 2, 1'b0, 1'b1);
        send_row(3, 8, 1'b0, 1'b1);
        drain();
        exp_q = '{10'h212, 10'h113};
        check_q("t3");
        chk("t3_err", {16'd0, err_short_lines}, EXP_ERR1);

        // Zero-width window then a normal frame
        set_win(2, 1, 0, 2);
        q.delete();
        send_frame();
        drain();
        chk("t4_empty", q.size(), 32'd0);
        set_win(2, 1, 4, 2);
        q.delete();
        send_frame();
        drain();
        exp_std();
        check_q("t4b");

        // New SOF injected part-way through row 2
        q.delete();
        send_row(0, 8, 1'b1, 1'b1);
        send_row(1, 8, 1'b0, 1'b1);
        send_row(2, 4, 1'b0, 1'b0);
        send_frame();
        drain();
        exp_q = '{10'h212, 10'h013, 10'h014, 10'h115, 10'h022, 10'h023,
                  10'h212, 10'h013, 10'h014, 10'h115, 10'h022, 10'h023, 10'h024, 10'h125};
        check_q("t5");
        chk("t5_err", {16'd0, err_short_lines}, EXP_ERR1);

        // Reset while a kept beat is stalled in the output register
        rdy = 1'b0;
        q.delete();
        send_row(0, 8, 1'b1, 1'b1);
        send_row(1, 3, 1'b0, 1'b0);
        chk("t6_valid",  {31'd0, m_axis_tvalid}, 32'd1);
        chk("t6_data",   {24'd0, m_axis_tdata}, 32'h12);
        chk("t6_sready", {31'd0, s_axis_tready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_clr", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t6_err_clr",   {16'd0, err_short_lines}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy   = 1'b1;
        for (int x = 3; x < 8; x++) begin
            logic [3:0] xx;
            xx = x[3:0];
            send_beat({4'h1, xx}, 1'b0, x == 7);
        end
        send_row(2, 8, 1'b0, 1'b1);
        send_row(3, 8, 1'b0, 1'b1);
        drain();
        chk("t6_dropped", q.size(), 32'd0);
        q.delete();
        send_frame();
        drain();
        exp_std();
        check_q("t6_resume");
        chk("t6_err_end", {16'd0, err_short_lines}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_crop.md
# axis_crop

Pixel-stream window extractor that sits directly upstream of the two-entry relay stage in the video path. It takes a raster pixel stream and forwards only the pixels inside a rectangular window, with start-of-frame (tuser) and end-of-line (tlast) regenerated for the cropped image. The window geometry is sampled once per frame. The output is a registered AXI-Stream master that feeds the relay's slave port.

## Interface
- C_PIXEL_WIDTH, 8, pixel data width
- C_IMG_WBITS, 12, width of column counter and horizontal window fields
- C_IMG_HBITS, 12, width of row counter and vertical window fields
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- win_left  in  C_IMG_WBITS  first kept column
- win_top  in  C_IMG_HBITS  first kept row
- win_width  in  C_IMG_WBITS  kept columns per row; 0 = nothing kept
- win_height  in  C_IMG_HBITS  kept rows; 0 = nothing kept
- s_axis_tvalid / s_axis_tdata / s_axis_tuser / s_axis_tlast  in  1/C_PIXEL_WIDTH/1/1  input stream; tuser = first pixel of frame, tlast = last pixel of line
- s_axis_tready  out  1
- m_axis_tvalid / m_axis_tdata / m_axis_tuser / m_axis_tlast  out  1/C_PIXEL_WIDTH/1/1  cropped stream
- m_axis_tready  in  1
- err_short_lines  out  16  saturating count of truncated window rows (see Configuration)

## Operation
- States: WAIT_SOF and ACTIVE. Reset enters WAIT_SOF.
- WAIT_SOF: accepted beats without tuser are discarded. An accepted beat with tuser samples win_* into shadow registers, sets x=0 and y=0, enters ACTIVE, and processes that beat as pixel (0,0).
- ACTIVE: each accepted beat is at (x,y).
  - inwin = (x ≥ L) && (x < L+W) && (y ≥ T) && (y < T+H).
  - Compare arithmetic uses C_IMG_WBITS+1 / C_IMG_HBITS+1 bits, so L+W and T+H never wrap.
- Accepted beat with inwin loads the output register:
  - m_tdata = s_tdata.
  - m_tuser = 1 only on the first kept pixel of the frame, tracked by a sent_sof flag cleared at each tuser.
  - m_tlast = 1 if x == L+W−1, or if s_tlast = 1 (short-line truncation).
- Accepted beat without inwin is consumed and dropped; the output register is not loaded.
- Column/row counting:
  - s_tlast → x=0, y=y+1.
  - Otherwise x=x+1.
  - x and y saturate at all-ones and do not wrap.
- tuser mid-frame while ACTIVE: treat as a new SOF. Resample the window, x=y=0, clear sent_sof. No tlast is synthesized for the abandoned partial row.
- W=0 or H=0: the frame produces no output beats.
- A window that lies outside the image produces only the overlap. A frame that ends early simply stops.
- Short line: a row with y in window whose s_tlast arrives at L ≤ x < L+W−1. That beat is output with tlast, and the error counter increments if enabled.
  - If s_tlast arrives at x < L, the row is empty: nothing is output and no error is counted.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, err_short_lines=0, state=WAIT_SOF.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational). Dropped beats obey the same ready.
- Latency: one cycle from accepted input beat to m_axis_tvalid.
- Full throughput: one beat per cycle when m_axis_tready is held high.
- m_axis_tvalid falls after an accepted output beat unless a new kept beat is accepted in the same cycle.
- m_axis_* stay stable while tvalid=1 and tready=0.
- Window inputs are only sampled at an accepted tuser beat. Changes between frames have no effect mid-frame.
- Reset asserted mid-frame clears the output register immediately (asynchronously). After release, the block discards beats until the next tuser.

## Configuration
- AXIS_CROP_ERRCNT_EN defined: err_short_lines counts short lines. It saturates at 16'hFFFF and clears only on reset.
- Not defined: the counter logic is absent and err_short_lines is tied to 0. The port list is unchanged.

## Structure
- Shared package holds:
  - state encoding localparams (ST_WAIT_SOF, ST_ACTIVE);
  - the error-counter width constant (16).
- One natural sub-module: axis_crop_oreg. It is the single-entry output register with its tready equation, reusable elsewhere in the pipeline.
- Coordinate counters, window compare and FSM stay in the top module.

## Test plan
- 8×4 frame, window L=2 T=1 W=4 H=2, m_tready=1 → 8 beats out: columns 2..5 of rows 1–2; tuser on the first beat only; tlast on beats 4 and 8; 1-cycle latency.
- Same frame with m_tready toggling 1/0 every cycle → identical data sequence; outputs held stable during stalls; no beats lost.
- Row 1 with tlast at x=3, window L=2 W=4 → output beats x=2,3 with tlast on x=3; err_short_lines=1 with the macro, 0 without.
- W=0 → zero output beats; the next frame with W=4 crops normally.
- tuser injected at row 2 of a frame → counters restart; the next kept beat carries tuser; the previous partial row ends without tlast.
- Reset pulsed while m_tvalid=1 mid-frame → m_tvalid=0 immediately; pre-tuser beats after release are dropped; output resumes at the next tuser.
